// File: rtl/e203_longpwbck_pkg.sv
// Shared defaults and buffer-entry layout for the long-pipe
// write-back collector.
package e203_longpwbck_pkg;

    localparam int DEF_NCH     = 2;
    localparam int DEF_FLEN    = 32;
    localparam int DEF_ITAG_W  = 1;
    localparam int DEF_RFIDX_W = 5;
    localparam int DEF_PC_W    = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_WDG_W   = 8;
    localparam int FLAG_W      = 5;

    typedef struct packed {
        logic [DEF_FLEN-1:0]    wdat;
        logic [FLAG_W-1:0]      flags;
        logic                   insterr;
        logic                   ld;
        logic                   st;
        logic                   buserr;
        logic [DEF_ADDR_W-1:0]  badaddr;
        logic [DEF_RFIDX_W-1:0] rdidx;
        logic                   rdfpu;
        logic [DEF_PC_W-1:0]    pc;
    } lpw_ent_t;

endpackage

// File: rtl/e203_exu_longpwbck_mc_if.sv
// Bundle of channel inputs, OITF head, and write-back/exception
// outputs of the long-pipe write-back collector.
interface e203_exu_longpwbck_mc_if
    import e203_longpwbck_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int FLEN    = DEF_FLEN,
    parameter int ITAG_W  = DEF_ITAG_W,
    parameter int RFIDX_W = DEF_RFIDX_W,
    parameter int PC_W    = DEF_PC_W,
    parameter int ADDR_W  = DEF_ADDR_W
);
    logic [NCH-1:0]        ch_wbck_i_valid;
    logic [NCH-1:0]        ch_wbck_i_ready;
    logic [NCH*FLEN-1:0]   ch_wbck_i_wdat;
    logic [NCH*5-1:0]      ch_wbck_i_flags;
    logic [NCH*ITAG_W-1:0] ch_wbck_i_itag;
    logic [NCH-1:0]        ch_wbck_i_err;
    logic [NCH-1:0]        ch_cmt_i_insterr;
    logic [NCH-1:0]        ch_cmt_i_ld;
    logic [NCH-1:0]        ch_cmt_i_st;
    logic [NCH-1:0]        ch_cmt_i_buserr;
    logic [NCH*ADDR_W-1:0] ch_cmt_i_badaddr;

    logic                  longp_wbck_o_valid;
    logic                  longp_wbck_o_ready;
    logic [FLEN-1:0]       longp_wbck_o_wdat;
    logic [4:0]            longp_wbck_o_flags;
    logic [RFIDX_W-1:0]    longp_wbck_o_rdidx;
    logic                  longp_wbck_o_rdfpu;

    logic                  longp_excp_o_valid;
    logic                  longp_excp_o_ready;
    logic                  longp_excp_o_insterr;
    logic                  longp_excp_o_ld;
    logic                  longp_excp_o_st;
    logic                  longp_excp_o_buserr;
    logic [ADDR_W-1:0]     longp_excp_o_badaddr;
    logic [PC_W-1:0]       longp_excp_o_pc;

    logic                  oitf_empty;
    logic [ITAG_W-1:0]     oitf_ret_ptr;
    logic [RFIDX_W-1:0]    oitf_ret_rdidx;
    logic [PC_W-1:0]       oitf_ret_pc;
    logic                  oitf_ret_rdwen;
    logic                  oitf_ret_rdfpu;
    logic                  oitf_ret_ena;
    logic                  wdg_timeout;

    modport master (
        output ch_wbck_i_valid, ch_wbck_i_wdat, ch_wbck_i_flags,
        output ch_wbck_i_itag, ch_wbck_i_err,
        output ch_cmt_i_insterr, ch_cmt_i_ld, ch_cmt_i_st,
        output ch_cmt_i_buserr, ch_cmt_i_badaddr,
        input  ch_wbck_i_ready,
        input  longp_wbck_o_valid, longp_wbck_o_wdat,
        input  longp_wbck_o_flags, longp_wbck_o_rdidx,
        input  longp_wbck_o_rdfpu,
        output longp_wbck_o_ready,
        input  longp_excp_o_valid, longp_excp_o_insterr,
        input  longp_excp_o_ld, longp_excp_o_st,
        input  longp_excp_o_buserr, longp_excp_o_badaddr,
        input  longp_excp_o_pc,
        output longp_excp_o_ready,
        output oitf_empty, oitf_ret_ptr, oitf_ret_rdidx,
        output oitf_ret_pc, oitf_ret_rdwen, oitf_ret_rdfpu,
        input  oitf_ret_ena, wdg_timeout
    );

    modport slave (
        input  ch_wbck_i_valid, ch_wbck_i_wdat, ch_wbck_i_flags,
        input  ch_wbck_i_itag, ch_wbck_i_err,
        input  ch_cmt_i_insterr, ch_cmt_i_ld, ch_cmt_i_st,
        input  ch_cmt_i_buserr, ch_cmt_i_badaddr,
        output ch_wbck_i_ready,
        output longp_wbck_o_valid, longp_wbck_o_wdat,
        output longp_wbck_o_flags, longp_wbck_o_rdidx,
        output longp_wbck_o_rdfpu,
        input  longp_wbck_o_ready,
        output longp_excp_o_valid, longp_excp_o_insterr,
        output longp_excp_o_ld, longp_excp_o_st,
        output longp_excp_o_buserr, longp_excp_o_badaddr,
        output longp_excp_o_pc,
        input  longp_excp_o_ready,
        input  oitf_empty, oitf_ret_ptr, oitf_ret_rdidx,
        input  oitf_ret_pc, oitf_ret_rdwen, oitf_ret_rdfpu,
        output oitf_ret_ena, wdg_timeout
    );

endinterface

// File: rtl/e203_longpwbck_prio.sv
// One-hot lowest-index priority picker.
module e203_longpwbck_prio #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    // scan high to low so the lowest requester is written last
    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/e203_exu_longpwbck_mc.sv
// Long-pipe write-back collector: picks the channel matching the
// OITF head, buffers it, and drives write-back/exception commit.
module e203_exu_longpwbck_mc
    import e203_longpwbck_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int FLEN    = DEF_FLEN,
    parameter int ITAG_W  = DEF_ITAG_W,
    parameter int RFIDX_W = DEF_RFIDX_W,
    parameter int PC_W    = DEF_PC_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int WDG_W   = DEF_WDG_W
) (
    input  logic clk,
    input  logic rst,
    e203_exu_longpwbck_mc_if.slave bus
);

    logic [NCH-1:0]   elig;
    logic [NCH-1:0]   gnt;
    logic [NCH-1:0]   rdy;
    logic             wbck_pend;
    logic             excp_pend;
    logic             nul_pend;
    logic             buf_empty;
    logic             cap;
    logic             wbck_hs;
    logic             excp_hs;
    logic             last_clr;
    logic             win_err;
    logic             wdg_inc;
    lpw_ent_t         ent;
    lpw_ent_t         win;
    logic [WDG_W-1:0] wdg_cnt;

    // a channel is eligible when it returns the OITF head's tag
    always_comb begin
        elig = '0;
        for (int c = 0; c < NCH; c++) begin
            elig[c] = bus.ch_wbck_i_valid[c] & ~bus.oitf_empty
                & (bus.ch_wbck_i_itag[c*ITAG_W +: ITAG_W]
                   == bus.oitf_ret_ptr);
        end
    end

    e203_longpwbck_prio #(
        .N (NCH)
    ) u_prio (
        .req (elig),
        .gnt (gnt)
    );

    // a null entry still occupies the buffer for its retire cycle
    assign buf_empty = ~wbck_pend & ~excp_pend & ~nul_pend;
    assign rdy       = gnt & {NCH{buf_empty & ~rst}};
    assign cap       = |rdy;
    assign bus.ch_wbck_i_ready = rdy;

    // mux the winning channel's fields together with the OITF head
    always_comb begin
        win     = '0;
        win_err = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (gnt[c]) begin
                win.wdat    = bus.ch_wbck_i_wdat[c*FLEN +: FLEN];
                win.flags   = bus.ch_wbck_i_flags[c*5 +: 5];
                win.insterr = bus.ch_cmt_i_insterr[c];
                win.ld      = bus.ch_cmt_i_ld[c];
                win.st      = bus.ch_cmt_i_st[c];
                win.buserr  = bus.ch_cmt_i_buserr[c];
                win.badaddr = bus.ch_cmt_i_badaddr[c*ADDR_W +: ADDR_W];
                win_err     = bus.ch_wbck_i_err[c];
            end
        end
        win.rdidx = bus.oitf_ret_rdidx;
        win.rdfpu = bus.oitf_ret_rdfpu;
        win.pc    = bus.oitf_ret_pc;
    end

    assign wbck_hs  = wbck_pend & bus.longp_wbck_o_ready;
    assign excp_hs  = excp_pend & bus.longp_excp_o_ready;
    assign last_clr = (wbck_hs | excp_hs)
                    & (wbck_hs | ~wbck_pend)
                    & (excp_hs | ~excp_pend);
    assign bus.oitf_ret_ena = ~rst & (last_clr | nul_pend);

    // one-entry buffer: capture when empty, drain per handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wbck_pend <= 1'b0;
            excp_pend <= 1'b0;
            nul_pend  <= 1'b0;
            ent       <= '0;
        end else if (cap) begin
            wbck_pend <= bus.oitf_ret_rdwen & ~win_err;
            excp_pend <= win_err;
            nul_pend  <= ~bus.oitf_ret_rdwen & ~win_err;
            ent       <= win;
        end else begin
            wbck_pend <= wbck_pend & ~wbck_hs;
            excp_pend <= excp_pend & ~excp_hs;
            nul_pend  <= 1'b0;
        end
    end

    assign wdg_inc = ~bus.oitf_empty & buf_empty & ~(|elig);

    // watchdog: counts stalled cycles at the OITF head, saturating
    always_ff @(posedge clk) begin
        if (rst || cap || bus.oitf_empty) begin
            wdg_cnt <= '0;
        end else if (wdg_inc && !(&wdg_cnt)) begin
            wdg_cnt <= wdg_cnt + 1'b1;
        end
    end

    assign bus.wdg_timeout = &wdg_cnt;

    assign bus.longp_wbck_o_valid = wbck_pend;
    assign bus.longp_wbck_o_wdat  = wbck_pend ? ent.wdat : '0;
    assign bus.longp_wbck_o_flags = wbck_pend ? ent.flags : '0;
    assign bus.longp_wbck_o_rdidx =
        wbck_pend ? ent.rdidx : RFIDX_W'(0);
    assign bus.longp_wbck_o_rdfpu = wbck_pend & ent.rdfpu;

    assign bus.longp_excp_o_valid   = excp_pend;
    assign bus.longp_excp_o_insterr = excp_pend & ent.insterr;
    assign bus.longp_excp_o_ld      = excp_pend & ent.ld;
    assign bus.longp_excp_o_st      = excp_pend & ent.st;
    assign bus.longp_excp_o_buserr  = excp_pend & ent.buserr;
    assign bus.longp_excp_o_badaddr = excp_pend ? ent.badaddr : '0;
    assign bus.longp_excp_o_pc      = excp_pend ? ent.pc : PC_W'(0);

endmodule

// File: tb/tb_e203_exu_longpwbck_mc.sv
// Scoreboard bench for the long-pipe write-back collector.
module tb_e203_exu_longpwbck_mc;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    typedef struct {
        logic [31:0] wdat;
        logic [4:0]  flags;
        logic [4:0]  rdidx;
        logic        rdfpu;
    } wb_exp_t;

    typedef struct {
        logic        insterr;
        logic        ld;
        logic        st;
        logic        buserr;
        logic [31:0] badaddr;
        logic [31:0] pc;
    } ex_exp_t;

    wb_exp_t wb_q[$];
    ex_exp_t ex_q[$];

    e203_exu_longpwbck_mc_if bus ();

    e203_exu_longpwbck_mc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act,
                         logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ch(int c, logic v, logic itag,
                          logic [31:0] wdat, logic [4:0] flags,
                          logic err, logic ie, logic ld, logic st,
                          logic be, logic [31:0] ba);
        bus.ch_wbck_i_valid[c]          = v;
        bus.ch_wbck_i_itag[c]           = itag;
        bus.ch_wbck_i_wdat[c*32 +: 32]  = wdat;
        bus.ch_wbck_i_flags[c*5 +: 5]   = flags;
        bus.ch_wbck_i_err[c]            = err;
        bus.ch_cmt_i_insterr[c]         = ie;
        bus.ch_cmt_i_ld[c]              = ld;
        bus.ch_cmt_i_st[c]              = st;
        bus.ch_cmt_i_buserr[c]          = be;
        bus.ch_cmt_i_badaddr[c*32 +: 32] = ba;
    endtask

    task automatic clr_ch(int c);
        set_ch(c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push_wb(logic [31:0] d, logic [4:0] f,
                           logic [4:0] ri, logic fp);
        wb_exp_t e;
        e.wdat = d; e.flags = f; e.rdidx = ri; e.rdfpu = fp;
        wb_q.push_back(e);
    endtask

    task automatic push_ex(logic ie, logic ld, logic st, logic be,
                           logic [31:0] ba, logic [31:0] pc);
        ex_exp_t e;
        e.insterr = ie; e.ld = ld; e.st = st; e.buserr = be;
        e.badaddr = ba; e.pc = pc;
        ex_q.push_back(e);
    endtask

    // monitor: compare every output handshake against the queues
    initial begin
        wb_exp_t w;
        ex_exp_t x;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus.longp_wbck_o_valid
                && bus.longp_wbck_o_ready) begin
                if (wb_q.size() == 0) begin
                    check("wbck_unexpected", 1, 0);
                end else begin
                    w = wb_q.pop_front();
                    check("wbck_wdat", bus.longp_wbck_o_wdat, w.wdat);
                    check("wbck_flags", bus.longp_wbck_o_flags, w.flags);
                    check("wbck_rdidx", bus.longp_wbck_o_rdidx, w.rdidx);
                    check("wbck_rdfpu", bus.longp_wbck_o_rdfpu, w.rdfpu);
                end
            end
            if (!rst && bus.longp_excp_o_valid
                && bus.longp_excp_o_ready) begin
                if (ex_q.size() == 0) begin
                    check("excp_unexpected", 1, 0);
                end else begin
                    x = ex_q.pop_front();
                    check("excp_insterr", bus.longp_excp_o_insterr,
                          x.insterr);
                    check("excp_ld", bus.longp_excp_o_ld, x.ld);
                    check("excp_st", bus.longp_excp_o_st, x.st);
                    check("excp_buserr", bus.longp_excp_o_buserr,
                          x.buserr);
                    check("excp_badaddr", bus.longp_excp_o_badaddr,
                          x.badaddr);
                    check("excp_pc", bus.longp_excp_o_pc, x.pc);
                end
            end
        end
    end

    // global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL tb_timeout: got no end, expected end");
        $fatal(1, "time limit");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        clr_ch(0);
        clr_ch(1);
        bus.longp_wbck_o_ready = 1'b0;
        bus.longp_excp_o_ready = 1'b0;
        bus.oitf_empty     = 1'b0;
        bus.oitf_ret_ptr   = 1'b0;
        bus.oitf_ret_rdidx = 5'd7;
        bus.oitf_ret_pc    = 32'h100;
        bus.oitf_ret_rdwen = 1'b1;
        bus.oitf_ret_rdfpu = 1'b0;
        set_ch(0, 1, 0, 32'h1, 0, 0, 0, 0, 0, 0, 0);

        // reset state, including ready gated during reset
        tick();
        tick();
        #1;
        check("rst_ready", bus.ch_wbck_i_ready, 2'b00);
        check("rst_wbck_valid", bus.longp_wbck_o_valid, 0);
        check("rst_excp_valid", bus.longp_excp_o_valid, 0);
        check("rst_ret_ena", bus.oitf_ret_ena, 0);
        check("rst_wdg", bus.wdg_timeout, 0);
        tick();
        rst = 1'b0;
        clr_ch(0);
        #1;
        check("post_rst_wbck_valid", bus.longp_wbck_o_valid, 0);
        check("post_rst_ret_ena", bus.oitf_ret_ena, 0);

        // S1: plain write-back on ch0
        tick();
        bus.longp_wbck_o_ready = 1'b1;
        bus.longp_excp_o_ready = 1'b1;
        set_ch(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("s1_ready", bus.ch_wbck_i_ready, 2'b01);
        push_wb(32'h1234, 0, 5'd7, 0);
        tick();
        clr_ch(0);
        #1;
        check("s1_wbck_valid", bus.longp_wbck_o_valid, 1);
        check("s1_excp_valid", bus.longp_excp_o_valid, 0);
        check("s1_ret_ena", bus.oitf_ret_ena, 1);
        check("s1_ready_full", bus.ch_wbck_i_ready, 2'b00);
        tick();
        #1;
        check("s1_wbck_valid_after", bus.longp_wbck_o_valid, 0);
        check("s1_ret_ena_after", bus.oitf_ret_ena, 0);

        // S2: bus error on ch1 goes only to the exception port
        tick();
        bus.oitf_ret_pc = 32'h200;
        set_ch(1, 1, 0, 32'hdead, 0, 1, 0, 0, 0, 1, 32'h80000010);
        #1;
        check("s2_ready", bus.ch_wbck_i_ready, 2'b10);
        push_ex(0, 0, 0, 1, 32'h80000010, 32'h200);
        tick();
        clr_ch(1);
        bus.oitf_ret_pc = 32'h300;
        #1;
        check("s2_excp_valid", bus.longp_excp_o_valid, 1);
        check("s2_wbck_valid", bus.longp_wbck_o_valid, 0);
        check("s2_wdat_zero", bus.longp_wbck_o_wdat, 0);
        check("s2_ret_ena", bus.oitf_ret_ena, 1);
        tick();
        #1;
        check("s2_excp_valid_after", bus.longp_excp_o_valid, 0);
        check("s2_badaddr_zero", bus.longp_excp_o_badaddr, 0);

        // S3: both channels match, ch0 wins; then ch1 later
        tick();
        bus.longp_wbck_o_ready = 1'b0;
        bus.oitf_ret_ptr = 1'b1;
        set_ch(0, 1, 1, 32'haaaa, 0, 0, 0, 0, 0, 0, 0);
        set_ch(1, 1, 1, 32'hbbbb, 5'h15, 0, 0, 0, 0, 0, 0);
        #1;
        check("s3_ready_prio", bus.ch_wbck_i_ready, 2'b01);
        push_wb(32'haaaa, 0, 5'd7, 0);
        tick();
        clr_ch(0);
        #1;
        check("s3_ready_busy", bus.ch_wbck_i_ready, 2'b00);
        check("s3_wbck_valid", bus.longp_wbck_o_valid, 1);
        check("s3_ret_hold", bus.oitf_ret_ena, 0);
        bus.longp_wbck_o_ready = 1'b1;
        #1;
        check("s3_ret_ena", bus.oitf_ret_ena, 1);
        tick();
        bus.oitf_ret_ptr = 1'b0;
        #1;
        check("s3_itag_mismatch", bus.ch_wbck_i_ready, 2'b00);
        check("s3_wbck_idle", bus.longp_wbck_o_valid, 0);
        tick();
        set_ch(1, 1, 0, 32'hbbbb, 5'h15, 0, 0, 0, 0, 0, 0);
        bus.oitf_ret_rdidx = 5'd3;
        bus.oitf_ret_rdfpu = 1'b1;
        #1;
        check("s3_ready_ch1", bus.ch_wbck_i_ready, 2'b10);
        push_wb(32'hbbbb, 5'h15, 5'd3, 1);
        tick();
        clr_ch(1);
        bus.oitf_ret_rdidx = 5'd7;
        bus.oitf_ret_rdfpu = 1'b0;
        #1;
        check("s3_ch1_valid", bus.longp_wbck_o_valid, 1);
        check("s3_ch1_ret", bus.oitf_ret_ena, 1);

        // S4: exception held by backpressure blocks capture
        tick();
        bus.longp_excp_o_ready = 1'b0;
        set_ch(0, 1, 0, 32'h0, 0, 1, 0, 1, 0, 0, 32'h1000);
        #1;
        check("s4_ready", bus.ch_wbck_i_ready, 2'b01);
        push_ex(0, 1, 0, 0, 32'h1000, 32'h300);
        tick();
        clr_ch(0);
        set_ch(1, 1, 0, 32'h5, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("s4_excp_held", bus.longp_excp_o_valid, 1);
            check("s4_no_capture", bus.ch_wbck_i_ready, 2'b00);
            check("s4_no_ret", bus.oitf_ret_ena, 0);
            tick();
        end
        bus.longp_excp_o_ready = 1'b1;
        #1;
        check("s4_ret_ena", bus.oitf_ret_ena, 1);
        tick();
        clr_ch(1);
        #1;
        check("s4_excp_done", bus.longp_excp_o_valid, 0);

        // S5: entry with no rd write and no error retires alone
        tick();
        bus.oitf_ret_rdwen = 1'b0;
        set_ch(0, 1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("s5_ready", bus.ch_wbck_i_ready, 2'b01);
        tick();
        clr_ch(0);
        #1;
        check("s5_ret_ena", bus.oitf_ret_ena, 1);
        check("s5_wbck_valid", bus.longp_wbck_o_valid, 0);
        check("s5_excp_valid", bus.longp_excp_o_valid, 0);
        check("s5_busy", bus.ch_wbck_i_ready, 2'b00);
        tick();
        bus.oitf_ret_rdwen = 1'b1;
        #1;
        check("s5_ret_pulse", bus.oitf_ret_ena, 0);

        // S6: watchdog saturates after 255 stalled cycles
        bus.oitf_empty = 1'b1;
        tick();
        bus.oitf_empty = 1'b0;
        set_ch(0, 1, 1, 32'h77, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 254; i++) tick();
        #1;
        check("s6_wdg_254", bus.wdg_timeout, 0);
        tick();
        #1;
        check("s6_wdg_255", bus.wdg_timeout, 1);
        tick();
        #1;
        check("s6_wdg_sat", bus.wdg_timeout, 1);
        set_ch(0, 1, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("s6_ready", bus.ch_wbck_i_ready, 2'b01);
        check("s6_wdg_still", bus.wdg_timeout, 1);
        push_wb(32'h77, 0, 5'd7, 0);
        tick();
        clr_ch(0);
        #1;
        check("s6_wdg_clear", bus.wdg_timeout, 0);
        check("s6_wbck_valid", bus.longp_wbck_o_valid, 1);

        // S7: reset discards a pending write-back
        tick();
        bus.longp_wbck_o_ready = 1'b0;
        set_ch(0, 1, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("s7_ready", bus.ch_wbck_i_ready, 2'b01);
        tick();
        #1;
        check("s7_wbck_valid", bus.longp_wbck_o_valid, 1);
        rst = 1'b1;
        bus.longp_wbck_o_ready = 1'b1;
        #1;
        check("s7_rst_no_ret", bus.oitf_ret_ena, 0);
        check("s7_rst_ready", bus.ch_wbck_i_ready, 2'b00);
        tick();
        #1;
        check("s7_wbck_cleared", bus.longp_wbck_o_valid, 0);
        check("s7_ret_after", bus.oitf_ret_ena, 0);
        clr_ch(0);
        rst = 1'b0;
        tick();
        #1;
        check("s7_idle", bus.longp_wbck_o_valid, 0);

        tick();
        check("wb_q_drained", wb_q.size(), 0);
        check("ex_q_drained", ex_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/e203_exu_longpwbck_mc.md
E203_EXU_LONGPWBCK_MC -- requirements
Module: e203_exu_longpwbck_mc

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  NCH 2 number of long-pipe source channels (ch0 = LSU, ch1 = NICE/muldiv), 1..8
  FLEN 32 write-back data width
  ITAG_W 1 OITF pointer width
  RFIDX_W 5 regfile index width
  PC_W 32 PC width
  ADDR_W 32 bad-address width
  WDG_W 8 watchdog counter width
REQ-002 SHALL have ports, one per line: name, direction, width, meaning; per-channel buses are flattened, channel c in slice c:
  clk in 1 clock
  rst in 1 synchronous active-high reset
  ch_wbck_i_valid in NCH per-channel valid
  ch_wbck_i_ready out NCH per-channel ready
  ch_wbck_i_wdat in NCH*FLEN result data
  ch_wbck_i_flags in NCH*5 FP flags
  ch_wbck_i_itag in NCH*ITAG_W instruction tag
  ch_wbck_i_err in NCH result carries exception
  ch_cmt_i_insterr/ld/st/buserr in NCH each exception qualifiers
  ch_cmt_i_badaddr in NCH*ADDR_W faulting address
  longp_wbck_o_valid/ready out/in 1 regfile write-back handshake
  longp_wbck_o_wdat out FLEN; longp_wbck_o_flags out 5; longp_wbck_o_rdidx out RFIDX_W; longp_wbck_o_rdfpu out 1
  longp_excp_o_valid/ready out/in 1 commit exception handshake
  longp_excp_o_insterr/ld/st/buserr out 1 each; longp_excp_o_badaddr out ADDR_W; longp_excp_o_pc out PC_W
  oitf_empty in 1; oitf_ret_ptr in ITAG_W; oitf_ret_rdidx in RFIDX_W; oitf_ret_pc in PC_W; oitf_ret_rdwen in 1; oitf_ret_rdfpu in 1
  oitf_ret_ena out 1 retire top OITF entry
  wdg_timeout out 1 no channel matched OITF top for 2^WDG_W-1 cycles

Function
REQ-003 Channel c SHALL be eligible when ch_wbck_i_valid[c], ~oitf_empty, and ch itag == oitf_ret_ptr; the lowest eligible index SHALL win.
REQ-004 A one-entry output buffer SHALL hold the winner's data, flags, exception fields, and OITF rdidx/rdfpu/pc, plus two pending bits: wbck_pend = rdwen & ~err, excp_pend = err.
REQ-005 ch_wbck_i_ready[c] SHALL be 1 only for the winning channel while the buffer is empty; capture SHALL occur on that handshake, and at most one capture SHALL occur per cycle.
REQ-006 longp_wbck_o_valid SHALL equal wbck_pend and longp_excp_o_valid SHALL equal excp_pend; both SHALL be driven only from registers, with no combinational path from any input.
REQ-007 Each pending bit SHALL clear on its own handshake, independently of the other; the buffer SHALL be empty when both are 0.
REQ-008 oitf_ret_ena SHALL pulse for one cycle in the cycle the last pending bit clears; a captured entry with rdwen=0 and err=0 SHALL set oitf_ret_ena in the cycle after capture and empty the buffer.
REQ-009 While the buffer is non-empty, no capture SHALL occur; peak throughput is one instruction per 2 cycles.
REQ-010 Exception outputs SHALL be zero whenever excp_pend=0, and wdat/flags SHALL be zero whenever wbck_pend=0.
REQ-011 The watchdog counter SHALL increment when ~oitf_empty, the buffer is empty, and there is no eligible channel; it SHALL clear on any capture or on oitf_empty; it SHALL saturate at all-ones; wdg_timeout SHALL equal (counter == all-ones).
REQ-012 A handshake on one output and a capture SHALL never coincide, because capture requires an empty buffer.

Reset
REQ-013 On rst=1 at a clk edge: pending bits 0, buffer data 0, watchdog 0. All valids, readies, oitf_ret_ena, and wdg_timeout SHALL read 0 during and after reset until a new capture.
REQ-014 Reset mid-operation SHALL discard a buffered entry without asserting oitf_ret_ena.

Structure
REQ-015 Parameter defaults and the buffer-entry field layout SHALL live in shared package e203_longpwbck_pkg.
REQ-016 The lowest-index eligible selection SHALL be a sub-module e203_longpwbck_prio (NCH-wide one-hot priority picker); everything else is in the top module.

Verification
REQ-017 Bench SHALL cover these scenarios:
  - ch0 valid, itag=0, ptr=0, rdwen=1, err=0, wdat=0x1234 -> ch0 ready cycle 0; wbck valid cycle 1 with wdat=0x1234; wbck ready=1 -> oitf_ret_ena cycle 1.
  - ch1 err=1, buserr=1, badaddr=0x80000010, rdwen=1 -> only excp valid; pc=oitf_ret_pc; ret_ena on excp handshake; wbck valid stays 0.
  - ch0 and ch1 both valid with itag=ptr -> ch0 captured; ch1 ready=0.
  - Buffer with excp_pend: excp ready held 0 for 5 cycles -> valid held, no capture, no ret_ena; ready=1 -> retire.
  - oitf_empty=0, no itag match for 255 cycles with WDG_W=8 -> wdg_timeout=1; a match then a capture -> 0 next cycle.
  - rst during pending wbck -> valid 0 next cycle, no ret_ena.
